// File: rtl/mic_axi_slave.sv
// rtl/mic_axi_slave.sv - AXI4-Lite register slave with read-pop sample FIFO for the Microphone IP
// Optional threshold interrupt is built only when MIC_AXI_IRQ_EN is defined.
module mic_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH         = 16,
    parameter int SAMPLE_W           = 16
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic                              sample_valid,
    input  logic [SAMPLE_W-1:0]               sample_data,
    output logic                              mic_en,
    output logic [15:0]                       clk_div,
    output logic                              irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   LVL_ONE  = 1;
    localparam logic [PW:0]   LVL_FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = 1;

    typedef enum logic [1:0] {WS_IDLE, WS_ADDR, WS_DATA, WS_RESP} wstate_t;
    typedef enum logic {RS_IDLE, RS_VALID} rstate_t;

    wstate_t wstate, wnext;
    rstate_t rstate, rnext;
    logic        awready_c, wready_c, wr_en;
    logic [2:0]  aw_idx_q, wr_idx, rd_idx;
    logic [31:0] wdata_q, wr_data, rd_data;
    logic [3:0]  wstrb_q, wr_strb;
    logic        rd_err, ar_hs;
    logic [31:0] ctrl, clkdiv, thresh, scratch;
    logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   level;
    logic          ovf, empty, full, push, pop, clr, w1c;
    logic          unused_bits;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] st);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = st[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return res;
    endfunction

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wstate <= WS_IDLE;
            rstate <= RS_IDLE;
        end else begin
            wstate <= wnext;
            rstate <= rnext;
        end
    end

    always_comb begin
        wnext     = wstate;
        awready_c = 1'b0;
        wready_c  = 1'b0;
        wr_en     = 1'b0;
        case (wstate)
            WS_IDLE: begin
                awready_c = 1'b1;
                wready_c  = 1'b1;
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    wnext = WS_RESP;
                    wr_en = 1'b1;
                end else if (S_AXI_AWVALID) begin
                    wnext = WS_ADDR;
                end else if (S_AXI_WVALID) begin
                    wnext = WS_DATA;
                end
            end
            WS_ADDR: begin
                wready_c = 1'b1;
                if (S_AXI_WVALID) begin
                    wnext = WS_RESP;
                    wr_en = 1'b1;
                end
            end
            WS_DATA: begin
                awready_c = 1'b1;
                if (S_AXI_AWVALID) begin
                    wnext = WS_RESP;
                    wr_en = 1'b1;
                end
            end
            WS_RESP: if (S_AXI_BREADY) wnext = WS_IDLE;
            default: wnext = WS_IDLE;
        endcase
    end

    always_comb begin
        rnext = rstate;
        case (rstate)
            RS_IDLE:  if (S_AXI_ARVALID) rnext = RS_VALID;
            RS_VALID: if (S_AXI_RREADY) rnext = RS_IDLE;
            default:  rnext = RS_IDLE;
        endcase
    end

    assign S_AXI_AWREADY = ARESETN && awready_c;
    assign S_AXI_WREADY  = ARESETN && wready_c;
    assign S_AXI_BVALID  = (wstate == WS_RESP);
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = ARESETN && (rstate == RS_IDLE);
    assign S_AXI_RVALID  = (rstate == RS_VALID);

    // Whichever half arrived first is taken from its holding register.
    assign wr_idx  = (wstate == WS_ADDR) ? aw_idx_q : S_AXI_AWADDR[4:2];
    assign wr_data = (wstate == WS_DATA) ? wdata_q : S_AXI_WDATA;
    assign wr_strb = (wstate == WS_DATA) ? wstrb_q : S_AXI_WSTRB;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_idx_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_idx_q <= S_AXI_AWADDR[4:2];
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl    <= '0;
            clkdiv  <= '0;
            thresh  <= '0;
            scratch <= '0;
        end else if (wr_en) begin
            case (wr_idx)
                3'd0:    ctrl    <= merge(ctrl, wr_data, wr_strb);
                3'd1:    clkdiv  <= merge(clkdiv, wr_data, wr_strb);
                3'd2:    thresh  <= merge(thresh, wr_data, wr_strb);
                3'd3:    scratch <= merge(scratch, wr_data, wr_strb);
                default: ;
            endcase
        end
    end

    assign clr   = wr_en && (wr_idx == 3'd0) && wr_strb[0] && wr_data[1];
    assign w1c   = wr_en && (wr_idx == 3'd5) && wr_data[18];
    assign empty = (level == '0);
    assign full  = (level == LVL_FULL);
    assign rd_idx = S_AXI_ARADDR[4:2];
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    // Pop decision uses the pre-push level, so a push cannot satisfy a same-cycle read.
    assign pop   = ar_hs && (rd_idx == 3'd4) && !empty;
    assign push  = sample_valid && (!full || pop) && !clr;

    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr] <= sample_data;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
                if (push && !pop)      level <= level + LVL_ONE;
                else if (pop && !push) level <= level - LVL_ONE;
            end
            if (sample_valid && full && !pop && !clr) ovf <= 1'b1;
            else if (w1c)                             ovf <= 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (rd_idx)
            3'd0: rd_data = ctrl;
            3'd1: rd_data = clkdiv;
            3'd2: rd_data = thresh;
            3'd3: rd_data = scratch;
            3'd4: begin
                if (empty) rd_err = 1'b1;
                else       rd_data = 32'(mem[rd_ptr]);
            end
            3'd5: rd_data = {13'd0, ovf, full, empty, 16'(level)};
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= 2'b00;
        end else if (ar_hs) begin
            S_AXI_RDATA <= rd_data;
            S_AXI_RRESP <= rd_err ? 2'b10 : 2'b00;
        end
    end

    assign mic_en  = ctrl[0];
    assign clk_div = clkdiv[15:0];

`ifdef MIC_AXI_IRQ_EN
    logic irq_q;
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) irq_q <= 1'b0;
        else          irq_q <= (thresh != '0) && (32'(level) >= thresh);
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_mic_axi_slave.sv
// tb/tb_mic_axi_slave.sv - directed self-checking bench for mic_axi_slave
module tb_mic_axi_slave;
    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [4:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID, S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY;
    logic [4:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID, S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        mic_en;
    logic [15:0] clk_div;
    logic        irq;

`ifdef MIC_AXI_IRQ_EN
    localparam logic [31:0] IRQ_EXP = 32'd1;
`else
    localparam logic [31:0] IRQ_EXP = 32'd0;
`endif

    int n_chk = 0;
    int n_fail = 0;

    mic_axi_slave dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .mic_en(mic_en), .clk_div(clk_div), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        bit          is_wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        logic [1:0]  resp;
        string       name;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timeout waiting for handshake", nm);
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit pv, input logic [15:0] pd);
        int n;
        bit aw_hs, w_hs;
        @(negedge ACLK);
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
        if (pv) begin sample_valid = 1'b1; sample_data = pd; end
        n = 0;
        while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 20) begin
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK); #1;
            if (pv) sample_valid = 1'b0;
            if (aw_hs) S_AXI_AWVALID = 1'b0;
            if (w_hs)  S_AXI_WVALID = 1'b0;
            if (S_AXI_AWVALID || S_AXI_WVALID) @(negedge ACLK);
            n++;
        end
        if (n >= 20) begin
            timeout("write_addr_data");
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        end
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
        if (n >= 20) timeout("write_resp");
        chk("bresp", 32'(S_AXI_BRESP), 32'd0);
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, input bit pv, input logic [15:0] pd,
                            output logic [31:0] d, output logic [1:0] r);
        int n;
        @(negedge ACLK);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        if (pv) begin sample_valid = 1'b1; sample_data = pd; end
        n = 0;
        while (!S_AXI_ARREADY && n < 20) begin @(negedge ACLK); n++; end
        if (n >= 20) timeout("read_addr");
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        if (pv) sample_valid = 1'b0;
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin @(negedge ACLK); n++; end
        if (n >= 20) timeout("read_data");
        d = S_AXI_RDATA;
        r = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp,
                          input logic [1:0] er, input bit pv, input logic [15:0] pd);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, pv, pd, d, r);
        chk({nm, "_data"}, d, exp);
        chk({nm, "_resp"}, 32'(r), 32'(er));
    endtask

    task automatic push(input logic [15:0] d);
        @(negedge ACLK);
        sample_valid = 1'b1; sample_data = d;
        @(posedge ACLK); #1;
        sample_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [31:0] d1, d2;
        logic [1:0]  r1;

        ARESETN = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        sample_valid = 1'b0; sample_data = '0;

        tbl.push_back('{1, 5'h00, 32'h1, 4'hF, 32'h0, 2'b00, "w_ctrl"});
        tbl.push_back('{1, 5'h04, 32'h2, 4'hF, 32'h0, 2'b00, "w_clkdiv"});
        tbl.push_back('{1, 5'h08, 32'h3, 4'hF, 32'h0, 2'b00, "w_thresh"});
        tbl.push_back('{1, 5'h0C, 32'h4, 4'hF, 32'h0, 2'b00, "w_scratch"});
        tbl.push_back('{0, 5'h00, 32'h0, 4'h0, 32'h1, 2'b00, "r_ctrl"});
        tbl.push_back('{0, 5'h04, 32'h0, 4'h0, 32'h2, 2'b00, "r_clkdiv"});
        tbl.push_back('{0, 5'h08, 32'h0, 4'h0, 32'h3, 2'b00, "r_thresh"});
        tbl.push_back('{0, 5'h0C, 32'h0, 4'h0, 32'h4, 2'b00, "r_scratch"});
        tbl.push_back('{1, 5'h0C, 32'hAB00_0000, 4'h8, 32'h0, 2'b00, "w_scratch_b3"});
        tbl.push_back('{0, 5'h0C, 32'h0, 4'h0, 32'hAB00_0004, 2'b00, "r_scratch_b3"});
        tbl.push_back('{1, 5'h08, 32'hFFFF_FFFF, 4'h2, 32'h0, 2'b00, "w_thresh_b1"});
        tbl.push_back('{0, 5'h0A, 32'h0, 4'h0, 32'h0000_FF03, 2'b00, "r_thresh_b1"});
        tbl.push_back('{1, 5'h18, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, "w_rsvd"});
        tbl.push_back('{0, 5'h18, 32'h0, 4'h0, 32'h0, 2'b00, "r_rsvd18"});
        tbl.push_back('{0, 5'h1C, 32'h0, 4'h0, 32'h0, 2'b00, "r_rsvd1c"});
        tbl.push_back('{0, 5'h10, 32'h0, 4'h0, 32'h0, 2'b10, "r_fifo_empty"});
        tbl.push_back('{0, 5'h14, 32'h0, 4'h0, 32'h0001_0000, 2'b00, "r_status_rst"});
        tbl.push_back('{1, 5'h08, 32'h0, 4'hF, 32'h0, 2'b00, "w_thresh_clr"});
        tbl.push_back('{0, 5'h08, 32'h0, 4'h0, 32'h0, 2'b00, "r_thresh_clr"});

        repeat (3) @(negedge ACLK);
        chk("rst_awready", 32'(S_AXI_AWREADY), 0);
        chk("rst_wready", 32'(S_AXI_WREADY), 0);
        chk("rst_arready", 32'(S_AXI_ARREADY), 0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("post_awready", 32'(S_AXI_AWREADY), 1);
        chk("post_wready", 32'(S_AXI_WREADY), 1);
        chk("post_arready", 32'(S_AXI_ARREADY), 1);
        chk("post_bvalid", 32'(S_AXI_BVALID), 0);
        chk("post_rvalid", 32'(S_AXI_RVALID), 0);
        chk("post_rdata", S_AXI_RDATA, 0);
        chk("post_mic_en", 32'(mic_en), 0);
        chk("post_clk_div", 32'(clk_div), 0);
        chk("post_irq", 32'(irq), 0);

        foreach (tbl[i]) begin
            if (tbl[i].is_wr) axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 1'b0, 16'h0);
            else rd_chk(tbl[i].name, tbl[i].addr, tbl[i].exp, tbl[i].resp, 1'b0, 16'h0);
        end
        chk("mic_en", 32'(mic_en), 1);
        chk("clk_div", 32'(clk_div), 32'h2);

        push(16'hA5A5);
        push(16'h1234);
        rd_chk("st_two", 5'h14, 32'h0000_0002, 2'b00, 1'b0, 16'h0);
        rd_chk("pop1", 5'h10, 32'h0000_A5A5, 2'b00, 1'b0, 16'h0);
        rd_chk("pop2", 5'h10, 32'h0000_1234, 2'b00, 1'b0, 16'h0);
        rd_chk("pop_empty", 5'h10, 32'h0, 2'b10, 1'b0, 16'h0);
        rd_chk("st_empty", 5'h14, 32'h0001_0000, 2'b00, 1'b0, 16'h0);

        for (int i = 0; i < 17; i++) push(16'h0100 + 16'(i));
        rd_chk("st_ovf", 5'h14, 32'h0006_0010, 2'b00, 1'b0, 16'h0);
        axi_write(5'h14, 32'h0004_0000, 4'hF, 1'b0, 16'h0);
        rd_chk("st_w1c", 5'h14, 32'h0002_0010, 2'b00, 1'b0, 16'h0);
        rd_chk("pop_full_push", 5'h10, 32'h0000_0100, 2'b00, 1'b1, 16'hBEEF);
        rd_chk("st_full_push", 5'h14, 32'h0002_0010, 2'b00, 1'b0, 16'h0);

        axi_write(5'h00, 32'h3, 4'hF, 1'b1, 16'h7777);
        rd_chk("st_clr", 5'h14, 32'h0001_0000, 2'b00, 1'b0, 16'h0);
        rd_chk("ctrl_clr", 5'h00, 32'h3, 2'b00, 1'b0, 16'h0);

        rd_chk("pop_empty_push", 5'h10, 32'h0, 2'b10, 1'b1, 16'h4321);
        rd_chk("st_one", 5'h14, 32'h0000_0001, 2'b00, 1'b0, 16'h0);
        rd_chk("pop_late", 5'h10, 32'h0000_4321, 2'b00, 1'b0, 16'h0);

        axi_write(5'h08, 32'h4, 4'hF, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) push(16'h0200 + 16'(i));
        chk("irq_lag", 32'(irq), 0);
        @(posedge ACLK); #1;
        chk("irq_set", 32'(irq), IRQ_EXP);
        rd_chk("irq_pop", 5'h10, 32'h0000_0200, 2'b00, 1'b0, 16'h0);
        chk("irq_clr", 32'(irq), 0);

        @(negedge ACLK);
        chk("stall_wready0", 32'(S_AXI_WREADY), 1);
        S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("stall_wready1", 32'(S_AXI_WREADY), 0);
        chk("stall_bvalid0", 32'(S_AXI_BVALID), 0);
        chk("stall_awready1", 32'(S_AXI_AWREADY), 1);
        S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        chk("stall_bvalid1", 32'(S_AXI_BVALID), 1);
        chk("stall_bresp", 32'(S_AXI_BRESP), 0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            if (!S_AXI_BVALID || S_AXI_AWREADY || S_AXI_WREADY) bad++;
        end
        chk("stall_hold", 32'(bad), 0);
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        chk("stall_bvalid_done", 32'(S_AXI_BVALID), 0);
        chk("stall_awready_done", 32'(S_AXI_AWREADY), 1);
        chk("stall_wready_done", 32'(S_AXI_WREADY), 1);
        rd_chk("stall_scratch", 5'h0C, 32'h55, 2'b00, 1'b0, 16'h0);

        fork
            axi_write(5'h0C, 32'h77, 4'hF, 1'b0, 16'h0);
            axi_read(5'h0C, 1'b0, 16'h0, d1, r1);
        join
        chk("same_cycle_old", d1, 32'h55);
        rd_chk("same_cycle_new", 5'h0C, 32'h77, 2'b00, 1'b0, 16'h0);

        @(negedge ACLK);
        S_AXI_AWADDR = 5'h04; S_AXI_WDATA = 32'h9; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 5'h00; S_AXI_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        d2 = {30'd0, S_AXI_BVALID, S_AXI_RVALID};
        chk("mid_inflight", d2, 32'h3);
        #2 ARESETN = 1'b0;
        #1;
        chk("mid_bvalid", 32'(S_AXI_BVALID), 0);
        chk("mid_rvalid", 32'(S_AXI_RVALID), 0);
        chk("mid_awready", 32'(S_AXI_AWREADY), 0);
        chk("mid_arready", 32'(S_AXI_ARREADY), 0);
        chk("mid_mic_en", 32'(mic_en), 0);
        chk("mid_rdata", S_AXI_RDATA, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("rel_awready", 32'(S_AXI_AWREADY), 1);
        rd_chk("rel_clkdiv", 5'h04, 32'h0, 2'b00, 1'b0, 16'h0);
        rd_chk("rel_status", 5'h14, 32'h0001_0000, 2'b00, 1'b0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
